// File: rtl/mandbort_pkg.sv
// Shared defaults and FSM state type for the Mandelbrot scan controller.
package mandbort_pkg;

  // Default fixed-point format: Q4.12 coordinates in a 16-bit word.
  localparam int WIDTH_DEF    = 16;
  localparam int REALW_DEF    = 4;

  // Iteration core limits.
  localparam int MAX_ITER_DEF = 100;
  localparam int ITERW_DEF    = $clog2(MAX_ITER_DEF);

  // Default raster geometry.
  localparam int H_RES_DEF    = 640;
  localparam int V_RES_DEF    = 480;

  // Number of cycles after a request in which a result from the core is
  // treated as stale (it still belongs to the previous pixel).
  localparam int GUARD_CYCLES = 2;

  // Scan controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } scan_state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mandbort_scan_ctrl.sv
// Raster scan controller: walks every pixel of a frame, hands each point to
// an external iteration core and writes the returned count to a framebuffer.
module mandbort_scan_ctrl
  import mandbort_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int REALW    = REALW_DEF,
  parameter int MAX_ITER = MAX_ITER_DEF,
  parameter int ITERW    = $clog2(MAX_ITER),
  parameter int H_RES    = H_RES_DEF,
  parameter int V_RES    = V_RES_DEF,
  parameter int ADDRW    = $clog2(H_RES * V_RES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] r0,
  input  logic signed [WIDTH-1:0] i0,
  input  logic signed [WIDTH-1:0] dr,
  input  logic signed [WIDTH-1:0] di,
  output logic                    busy,
  output logic                    done,
  output logic                    core_req,
  output logic signed [WIDTH-1:0] core_rc,
  output logic signed [WIDTH-1:0] core_ic,
  input  logic                    core_vld,
  input  logic [ITERW-1:0]        core_iter,
  output logic                    fb_wr,
  output logic [ADDRW-1:0]        fb_addr,
  output logic [ITERW-1:0]        fb_data,
  input  logic                    fb_rdy
);

  localparam int XW = cnt_width(H_RES);
  localparam int YW = cnt_width(V_RES);
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic GUARD_LAST = 1'(GUARD_CYCLES - 1);

  // Catch parameter sets that cannot describe a sensible configuration.
  if (REALW < 1 || REALW >= WIDTH) begin : g_realw_chk
    $error("mandbort_scan_ctrl: REALW must lie in 1..WIDTH-1");
  end
  if ((2 ** ITERW) < MAX_ITER) begin : g_iterw_chk
    $error("mandbort_scan_ctrl: ITERW too narrow for MAX_ITER");
  end

  // State and datapath registers.
  scan_state_e              state_q, state_d;
  logic [XW-1:0]            x_q, x_d;
  logic [YW-1:0]            y_q, y_d;
  logic [ADDRW-1:0]         addr_q, addr_d;
  logic                     guard_cnt_q, guard_cnt_d;
  logic signed [WIDTH-1:0]  r0_q, r0_d;
  logic signed [WIDTH-1:0]  dr_q, dr_d;
  logic signed [WIDTH-1:0]  di_q, di_d;
  logic signed [WIDTH-1:0]  rc_acc_q, rc_acc_d;
  logic signed [WIDTH-1:0]  ic_acc_q, ic_acc_d;

  // Registered outputs.
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     core_req_q, core_req_d;
  logic signed [WIDTH-1:0]  core_rc_q, core_rc_d;
  logic signed [WIDTH-1:0]  core_ic_q, core_ic_d;
  logic                     fb_wr_q, fb_wr_d;
  logic [ITERW-1:0]         fb_data_q, fb_data_d;

  // Next-state, counter/accumulator update and output decode.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    guard_cnt_d = guard_cnt_q;
    r0_d        = r0_q;
    dr_d        = dr_q;
    di_d        = di_q;
    rc_acc_d    = rc_acc_q;
    ic_acc_d    = ic_acc_q;
    core_rc_d   = core_rc_q;
    core_ic_d   = core_ic_q;
    fb_data_d   = fb_data_q;

    case (state_q)
      ST_IDLE: begin
        // The frame parameters are snapshotted here so that later changes
        // on the inputs cannot disturb a scan in progress.
        if (start) begin
          r0_d     = r0;
          dr_d     = dr;
          di_d     = di;
          rc_acc_d = r0;
          ic_acc_d = i0;
          x_d      = '0;
          y_d      = '0;
          addr_d   = '0;
          state_d  = ST_REQ;
        end
      end

      ST_REQ: begin
        // Present the point; it stays on core_rc/core_ic until the next REQ.
        core_rc_d   = rc_acc_q;
        core_ic_d   = ic_acc_q;
        guard_cnt_d = 1'b0;
        state_d     = ST_GUARD;
      end

      ST_GUARD: begin
        // core_vld may still be high from the previous pixel; ignore it.
        if (guard_cnt_q == GUARD_LAST) begin
          state_d = ST_WAIT;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end

      ST_WAIT: begin
        if (core_vld) begin
          fb_data_d = core_iter;
          state_d   = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (fb_rdy) begin
          if (x_q != X_LAST) begin
            x_d      = x_q + 1'b1;
            addr_d   = addr_q + 1'b1;
            rc_acc_d = rc_acc_q + dr_q;
            state_d  = ST_REQ;
          end else if (y_q != Y_LAST) begin
            // Imaginary axis runs downward: each new line subtracts di.
            x_d      = '0;
            y_d      = y_q + 1'b1;
            addr_d   = addr_q + 1'b1;
            rc_acc_d = r0_q;
            ic_acc_d = ic_acc_q - di_q;
            state_d  = ST_REQ;
          end else begin
            state_d  = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered; most are decoded from the upcoming state so
    // they line up with it, while core_req lags REQ by one cycle so the
    // point registers are already loaded when the pulse is seen.
    core_req_d = (state_q == ST_REQ);
    fb_wr_d    = (state_d == ST_WRITE);
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d == ST_REQ)  || (state_d == ST_GUARD) ||
                 (state_d == ST_WAIT) || (state_d == ST_WRITE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      guard_cnt_q <= 1'b0;
      r0_q        <= '0;
      dr_q        <= '0;
      di_q        <= '0;
      rc_acc_q    <= '0;
      ic_acc_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      core_req_q  <= 1'b0;
      core_rc_q   <= '0;
      core_ic_q   <= '0;
      fb_wr_q     <= 1'b0;
      fb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      guard_cnt_q <= guard_cnt_d;
      r0_q        <= r0_d;
      dr_q        <= dr_d;
      di_q        <= di_d;
      rc_acc_q    <= rc_acc_d;
      ic_acc_q    <= ic_acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      core_req_q  <= core_req_d;
      core_rc_q   <= core_rc_d;
      core_ic_q   <= core_ic_d;
      fb_wr_q     <= fb_wr_d;
      fb_data_q   <= fb_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign core_req = core_req_q;
  assign core_rc  = core_rc_q;
  assign core_ic  = core_ic_q;
  assign fb_wr    = fb_wr_q;
  assign fb_addr  = addr_q;
  assign fb_data  = fb_data_q;

endmodule

// File: tb/tb_mandbort_scan_ctrl.sv
// Scoreboard bench for mandbort_scan_ctrl on a 4x2 raster with a
// behavioural iteration core that keeps a stale result alive through GUARD.
module tb_mandbort_scan_ctrl;

  localparam int WIDTH = 16;
  localparam int ITERW = 7;
  localparam int H_RES = 4;
  localparam int V_RES = 2;
  localparam int ADDRW = 3;
  localparam int NPIX  = H_RES * V_RES;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  r0 = '0, i0 = '0, dr = '0, di = '0;
  logic              busy, done, core_req;
  logic [WIDTH-1:0]  core_rc, core_ic;
  logic              core_vld = 1'b0;
  logic [ITERW-1:0]  core_iter = '0;
  logic              fb_wr;
  logic [ADDRW-1:0]  fb_addr;
  logic [ITERW-1:0]  fb_data;
  logic              fb_rdy = 1'b1;

  mandbort_scan_ctrl #(
    .WIDTH(WIDTH), .REALW(4), .MAX_ITER(100), .ITERW(ITERW),
    .H_RES(H_RES), .V_RES(V_RES), .ADDRW(ADDRW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .r0(r0), .i0(i0), .dr(dr), .di(di),
    .busy(busy), .done(done),
    .core_req(core_req), .core_rc(core_rc), .core_ic(core_ic),
    .core_vld(core_vld), .core_iter(core_iter),
    .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_data(fb_data), .fb_rdy(fb_rdy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [ITERW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int errors = 0;
  int checks = 0;

  // Frame configuration as seen by the bench.
  logic [WIDTH-1:0] cfg_r0, cfg_i0, cfg_dr, cfg_di;
  int px = 0;
  int writes_in_frame = 0;
  int done_cnt = 0;
  int max_delay = 0;
  int stall_addr = -1;
  int stall_left = 0;
  logic [WIDTH-1:0] rc_seen [NPIX];
  logic [WIDTH-1:0] ic_seen [NPIX];

  // Core model state.
  bit               pend = 0;
  int               cd = 0;
  int               extra = 0;
  logic [ITERW-1:0] new_iter = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    check_val("rst_busy",     32'(busy), 0);
    check_val("rst_done",     32'(done), 0);
    check_val("rst_core_req", 32'(core_req), 0);
    check_val("rst_fb_wr",    32'(fb_wr), 0);
    check_val("rst_fb_addr",  32'(fb_addr), 0);
    check_val("rst_fb_data",  32'(fb_data), 0);
    check_val("rst_core_rc",  32'(core_rc), 0);
    check_val("rst_core_ic",  32'(core_ic), 0);
  endtask

  function automatic logic [WIDTH-1:0] exp_rc(input int p);
    logic [WIDTH-1:0] x;
    x = WIDTH'(p % H_RES);
    return cfg_r0 + x * cfg_dr;
  endfunction

  function automatic logic [WIDTH-1:0] exp_ic(input int p);
    logic [WIDTH-1:0] y;
    y = WIDTH'(p / H_RES);
    return cfg_i0 - y * cfg_di;
  endfunction

  // Monitor plus core/framebuffer model, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        // Core result timing: stale value survives two cycles after the
        // request, then the new result appears after 'extra' more cycles.
        if (pend) begin
          cd--;
          if (cd == extra) begin
            if (extra == 0) begin
              core_vld = 1'b1; core_iter = new_iter; pend = 0;
            end else begin
              core_vld = 1'b0;
            end
          end else if (cd == 0) begin
            core_vld = 1'b1; core_iter = new_iter; pend = 0;
          end
        end
        if (core_req) begin
          check_val("core_rc", 32'(core_rc), 32'(exp_rc(px)));
          check_val("core_ic", 32'(core_ic), 32'(exp_ic(px)));
          if (px < NPIX) begin
            rc_seen[px] = core_rc;
            ic_seen[px] = core_ic;
          end
          do new_iter = ITERW'($urandom_range(0, 99)); while (new_iter == core_iter);
          extra = $urandom_range(0, max_delay);
          cd = 2 + extra;
          pend = 1;
          sb.push_back(wr_t'{addr: ADDRW'(px), data: new_iter});
          $display("req  px=%0d rc=0x%04h ic=0x%04h iter=%0d", px, core_rc, core_ic, new_iter);
          px++;
        end
        if (fb_wr) begin
          if (stall_left > 0 && int'(fb_addr) == stall_addr) begin
            fb_rdy = 1'b0;
            stall_left--;
            check_val("stall_addr", 32'(fb_addr), 32'(stall_addr));
            check_val("stall_req",  32'(core_req), 0);
            if (sb.size() > 0) check_val("stall_data", 32'(fb_data), 32'(sb[0].data));
          end else begin
            fb_rdy = 1'b1;
            if (sb.size() == 0) begin
              check_val("sb_empty", 32'(sb.size()), 1);
            end else begin
              wr_t e;
              e = sb.pop_front();
              check_val("fb_addr", 32'(fb_addr), 32'(e.addr));
              check_val("fb_data", 32'(fb_data), 32'(e.data));
            end
            $display("wr   addr=%0d data=%0d", fb_addr, fb_data);
            writes_in_frame++;
          end
        end
        if (done) begin
          check_val("frame_writes", writes_in_frame, NPIX);
          check_val("done_busy", 32'(busy), 0);
          check_val("sb_drained", sb.size(), 0);
          $display("done frame writes=%0d", writes_in_frame);
          done_cnt++;
        end
      end
    end
  end

  task automatic start_frame(input logic [WIDTH-1:0] a_r0, input logic [WIDTH-1:0] a_i0,
                             input logic [WIDTH-1:0] a_dr, input logic [WIDTH-1:0] a_di);
    @(negedge clk);
    r0 = a_r0; i0 = a_i0; dr = a_dr; di = a_di;
    cfg_r0 = a_r0; cfg_i0 = a_i0; cfg_dr = a_dr; cfg_di = a_di;
    px = 0;
    writes_in_frame = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", 32'(busy), 1);
    check_val("req_lat1", 32'(core_req), 0);
    @(negedge clk);
    check_val("req_lat2", 32'(core_req), 1);
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) seen = 1;
    end
    check_val("done_seen", 32'(seen), 1);
  endtask

  task automatic wait_px(input int target, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (px >= target) seen = 1;
    end
    check_val("px_reached", 32'(seen), 1);
  endtask

  initial begin
    int d_before;
    // Reset state.
    #2;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Frame 1: reference scan, immediate results, always ready.
    max_delay = 0;
    start_frame(16'hE000, 16'h1000, 16'h0400, 16'h0800);
    wait_done(400);
    check_val("f1_rc0", 32'(rc_seen[0]), 32'h0000_E000);
    check_val("f1_rc1", 32'(rc_seen[1]), 32'h0000_E400);
    check_val("f1_rc3", 32'(rc_seen[3]), 32'h0000_EC00);
    check_val("f1_rc4", 32'(rc_seen[4]), 32'h0000_E000);
    check_val("f1_ic0", 32'(ic_seen[0]), 32'h0000_1000);
    check_val("f1_ic4", 32'(ic_seen[4]), 32'h0000_0800);
    check_val("f1_done_cnt", done_cnt, 1);

    // Frame 2: random core latency and a 5-cycle framebuffer stall at addr 3.
    max_delay = 3;
    stall_addr = 3;
    stall_left = 5;
    start_frame(16'h2000, 16'hF000, 16'h0100, 16'h0200);
    wait_done(600);
    check_val("f2_stall_used", stall_left, 0);
    stall_addr = -1;

    // Frame 3: start pulse and parameter changes mid-frame are ignored.
    start_frame(16'h0100, 16'h0200, 16'h0010, 16'h0020);
    wait_px(3, 300);
    @(negedge clk);
    start = 1'b1;
    r0 = 16'h1234; i0 = 16'h4321; dr = 16'h0F00; di = 16'h0A00;
    @(negedge clk);
    start = 1'b0;
    wait_done(600);
    check_val("f3_done_cnt", done_cnt, 3);

    // Frame 4: asynchronous reset at pixel 5 abandons the scan.
    start_frame(16'hE000, 16'h1000, 16'h0400, 16'h0800);
    wait_px(6, 300);
    d_before = done_cnt;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs();
    pend = 0; core_vld = 1'b0; core_iter = '0;
    sb.delete();
    px = 0; fb_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_val("abort_no_done", done_cnt, d_before);
    check_val("abort_idle_busy", 32'(busy), 0);

    // Frame 5: restart at pixel 0 with wrapping real coordinate.
    max_delay = 1;
    start_frame(16'h7C00, 16'h0000, 16'h0800, 16'h0100);
    wait_done(500);
    check_val("f5_rc0", 32'(rc_seen[0]), 32'h0000_7C00);
    check_val("f5_rc1_wrap", 32'(rc_seen[1]), 32'h0000_8400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
